// File: rtl/vedic_mac_acc.sv
// Accumulates unsigned 16-bit Vedic multiplier products into a wide sum, closing a block after LEN products or on p_last.
// Latency: accept-to-acc_out 1 cycle; acc_valid rises on the edge that adds the closing product.
// Backpressure: p_ready drops while a finished sum waits in HOLD; one bubble cycle follows each output handshake.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   p_in/p_valid/p_last   product input; p_last is sampled only on accept
//   p_ready               combinational from state: !rst && state != HOLD
//   acc_out/acc_valid     registered result; acc_ready completes the output handshake
//   count, ovf, busy      products taken in this block, sticky overflow, state == ACCUM
//
// Optional build macro: VEDIC_MAC_SAT_EN
//   defined   -> acc_out clamps to all-ones on overflow
//   undefined -> acc_out wraps modulo 2^ACC_W
module vedic_mac_acc #(
  parameter int ACC_W = 24,
  parameter int LEN   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      p_in,
  input  logic             p_valid,
  input  logic             p_last,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  logic [1:0]       state;
  logic             accept;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             close;

  assign p_ready = !rst && (state != HOLD);
  assign busy    = (state == ACCUM);
  assign accept  = p_valid && p_ready;

  // One extra bit so the carry out of the accumulator is visible as overflow.
  assign sum     = {1'b0, acc_out} + {{(ACC_W-15){1'b0}}, p_in};
  assign cnt_nxt = count + 1'b1;
  // Reaching LEN and an early p_last on the same product form a single close.
  assign close   = (cnt_nxt == LEN_C) || p_last;

`ifdef VEDIC_MAC_SAT_EN
  // Once clamped, any further nonzero product overflows again, so the sum
  // stays pinned at all-ones for the rest of the block.
  assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_out   <= '0;
      count     <= '0;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_out <= acc_nxt;
            count   <= cnt_nxt;
            if (sum[ACC_W]) begin
              ovf <= 1'b1;
            end
            if (close) begin
              state     <= HOLD;
              acc_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // Result frozen until downstream takes it; the restart waits one
          // cycle because p_ready is decoded from the registered state.
          if (acc_valid && acc_ready) begin
            acc_out   <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            acc_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Directed bench for vedic_mac_acc: three instances cover LEN=4/ACC_W=24,
// LEN=8/ACC_W=18 and LEN=1/ACC_W=24 with a shared clock and reset.
module tb_vedic_mac_acc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  // LEN=4, ACC_W=24
  logic [15:0] a_in;
  logic        a_valid, a_last, a_ready, a_acc_valid, a_acc_ready, a_ovf, a_busy;
  logic [23:0] a_acc;
  logic [3:0]  a_cnt;
  // LEN=8, ACC_W=18
  logic [15:0] b_in;
  logic        b_valid, b_last, b_ready, b_acc_valid, b_acc_ready, b_ovf, b_busy;
  logic [17:0] b_acc;
  logic [3:0]  b_cnt;
  // LEN=1, ACC_W=24
  logic [15:0] c_in;
  logic        c_valid, c_last, c_ready, c_acc_valid, c_acc_ready, c_ovf, c_busy;
  logic [23:0] c_acc;
  logic [3:0]  c_cnt;

  vedic_mac_acc #(.ACC_W(24), .LEN(4), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .p_in(a_in), .p_valid(a_valid), .p_last(a_last),
    .p_ready(a_ready), .acc_out(a_acc), .acc_valid(a_acc_valid),
    .acc_ready(a_acc_ready), .count(a_cnt), .ovf(a_ovf), .busy(a_busy));

  vedic_mac_acc #(.ACC_W(18), .LEN(8), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .p_in(b_in), .p_valid(b_valid), .p_last(b_last),
    .p_ready(b_ready), .acc_out(b_acc), .acc_valid(b_acc_valid),
    .acc_ready(b_acc_ready), .count(b_cnt), .ovf(b_ovf), .busy(b_busy));

  vedic_mac_acc #(.ACC_W(24), .LEN(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .p_in(c_in), .p_valid(c_valid), .p_last(c_last),
    .p_ready(c_ready), .acc_out(c_acc), .acc_valid(c_acc_valid),
    .acc_ready(c_acc_ready), .count(c_cnt), .ovf(c_ovf), .busy(c_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_in = '0; a_valid = 0; a_last = 0; a_acc_ready = 0;
    b_in = '0; b_valid = 0; b_last = 0; b_acc_ready = 0;
    c_in = '0; c_valid = 0; c_last = 0; c_acc_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    asserts++; if (a_acc !== 24'd0 || a_cnt !== 4'd0 || a_acc_valid !== 1'b0 || a_ovf !== 1'b0 || a_busy !== 1'b0) begin
      fails++; $display("FAIL reset_state acc=%0d cnt=%0d vld=%b ovf=%b busy=%b exp all 0", a_acc, a_cnt, a_acc_valid, a_ovf, a_busy); end
    asserts++; if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_p_ready got %b exp 1", a_ready); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [4] = '{16'd15, 16'd120, 16'd400, 16'd49};
    do_reset();
    a_acc_ready = 1;
    for (int i = 0; i < 4; i++) begin
      a_in = v[i]; a_valid = 1;
      tick();
      if (i == 0) begin
        asserts++; if (a_acc !== 24'd15 || a_busy !== 1'b1) begin
          fails++; $display("FAIL b2b_first acc=%0d busy=%b exp 15/1", a_acc, a_busy); end
      end
    end
    a_valid = 0;
    asserts++; if (a_acc_valid !== 1'b1 || a_acc !== 24'd584 || a_cnt !== 4'd4 || a_ovf !== 1'b0) begin
      fails++; $display("FAIL b2b_result vld=%b acc=%0d cnt=%0d ovf=%b exp 1/584/4/0", a_acc_valid, a_acc, a_cnt, a_ovf); end
    asserts++; if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
      fails++; $display("FAIL b2b_hold_ready p_ready=%b busy=%b exp 0/0", a_ready, a_busy); end
    tick();
    asserts++; if (a_acc_valid !== 1'b0 || a_acc !== 24'd0 || a_cnt !== 4'd0 || a_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_clear vld=%b acc=%0d cnt=%0d rdy=%b exp 0/0/0/1", a_acc_valid, a_acc, a_cnt, a_ready); end
  endtask

  task automatic test_hold_backpressure();
    logic [15:0] v [4] = '{16'd15, 16'd120, 16'd400, 16'd49};
    do_reset();
    a_acc_ready = 0;
    for (int i = 0; i < 4; i++) begin
      a_in = v[i]; a_valid = 1;
      tick();
    end
    a_in = 16'd100;   // upstream keeps offering the next block's product
    for (int k = 0; k < 3; k++) begin
      asserts++; if (a_ready !== 1'b0 || a_acc !== 24'd584 || a_acc_valid !== 1'b1 || a_cnt !== 4'd4) begin
        fails++; $display("FAIL hold_cyc%0d rdy=%b acc=%0d vld=%b cnt=%0d exp 0/584/1/4", k, a_ready, a_acc, a_acc_valid, a_cnt); end
      if (k < 2) tick();
    end
    a_acc_ready = 1;
    tick();
    asserts++; if (a_acc_valid !== 1'b0 || a_acc !== 24'd0 || a_ready !== 1'b1) begin
      fails++; $display("FAIL hold_bubble vld=%b acc=%0d rdy=%b exp 0/0/1", a_acc_valid, a_acc, a_ready); end
    tick();
    a_valid = 0;
    asserts++; if (a_acc !== 24'd100 || a_cnt !== 4'd1 || a_busy !== 1'b1) begin
      fails++; $display("FAIL hold_restart acc=%0d cnt=%0d busy=%b exp 100/1/1", a_acc, a_cnt, a_busy); end
  endtask

  task automatic test_early_last();
    do_reset();
    b_in = 16'd15; b_valid = 1;
    tick();
    b_valid = 0;
    repeat (5) tick();
    asserts++; if (b_acc !== 18'd15 || b_cnt !== 4'd1 || b_busy !== 1'b1 || b_acc_valid !== 1'b0) begin
      fails++; $display("FAIL gap_hold acc=%0d cnt=%0d busy=%b vld=%b exp 15/1/1/0", b_acc, b_cnt, b_busy, b_acc_valid); end
    b_in = 16'd120; b_valid = 1; b_last = 1;
    tick();
    b_valid = 0; b_last = 0;
    asserts++; if (b_acc !== 18'd135 || b_cnt !== 4'd2 || b_acc_valid !== 1'b1 || b_ready !== 1'b0) begin
      fails++; $display("FAIL last_result acc=%0d cnt=%0d vld=%b rdy=%b exp 135/2/1/0", b_acc, b_cnt, b_acc_valid, b_ready); end
    b_acc_ready = 1;
    tick();
    b_acc_ready = 0;
    asserts++; if (b_acc_valid !== 1'b0 || b_acc !== 18'd0) begin
      fails++; $display("FAIL last_clear vld=%b acc=%0d exp 0/0", b_acc_valid, b_acc); end
  endtask

  task automatic test_overflow();
    logic [17:0] exp_acc;
`ifdef VEDIC_MAC_SAT_EN
    exp_acc = 18'd262143;
`else
    exp_acc = 18'd62981;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b_in = 16'd65025; b_valid = 1; b_last = (i == 4);
      tick();
      if (i == 3) begin
        asserts++; if (b_acc !== 18'd260100 || b_ovf !== 1'b0) begin
          fails++; $display("FAIL ovf_pre acc=%0d ovf=%b exp 260100/0", b_acc, b_ovf); end
      end
    end
    b_valid = 0; b_last = 0;
    asserts++; if (b_acc !== exp_acc || b_ovf !== 1'b1 || b_acc_valid !== 1'b1 || b_cnt !== 4'd5) begin
      fails++; $display("FAIL ovf_result acc=%0d ovf=%b vld=%b cnt=%0d exp %0d/1/1/5", b_acc, b_ovf, b_acc_valid, b_cnt, exp_acc); end
    b_acc_ready = 1;
    tick();
    b_acc_ready = 0;
    asserts++; if (b_ovf !== 1'b0 || b_acc !== 18'd0) begin
      fails++; $display("FAIL ovf_clear ovf=%b acc=%0d exp 0/0", b_ovf, b_acc); end
  endtask

  // Pulse rst for one cycle and check the discard; tag names the scenario.
  task automatic pulse_rst_check(input string tag);
    rst = 1;
    #1;
    asserts++; if (a_ready !== 1'b0) begin fails++; $display("FAIL %s_rdy_in_rst got %b exp 0", tag, a_ready); end
    @(posedge clk); #1;
    rst = 0;
    #1;
    asserts++; if (a_acc_valid !== 1'b0 || a_cnt !== 4'd0 || a_acc !== 24'd0 || a_ready !== 1'b1) begin
      fails++; $display("FAIL %s_after vld=%b cnt=%0d acc=%0d rdy=%b exp 0/0/0/1", tag, a_acc_valid, a_cnt, a_acc, a_ready); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_in = 16'd1000; a_valid = 1;
      tick();
    end
    a_valid = 0;
    pulse_rst_check("rst_mid");
    for (int i = 0; i < 4; i++) begin
      a_in = 16'd7; a_valid = 1;
      tick();
    end
    a_valid = 0;
    asserts++; if (a_acc_valid !== 1'b1) begin fails++; $display("FAIL rst_hold_setup vld=%b exp 1", a_acc_valid); end
    pulse_rst_check("rst_hold");
    for (int i = 0; i < 4; i++) begin
      a_in = 16'd65025; a_valid = 1;
      tick();
    end
    a_valid = 0;
    asserts++; if (a_acc !== 24'd260100 || a_acc_valid !== 1'b1 || a_ovf !== 1'b0) begin
      fails++; $display("FAIL rst_followup acc=%0d vld=%b ovf=%b exp 260100/1/0", a_acc, a_acc_valid, a_ovf); end
  endtask

  task automatic test_len1();
    logic [15:0] v [3] = '{16'd1, 16'd65025, 16'd0};
    do_reset();
    c_acc_ready = 1;
    for (int i = 0; i < 3; i++) begin
      c_in = v[i]; c_valid = 1;
      tick();
      c_valid = 0;
      asserts++; if (c_acc_valid !== 1'b1 || c_acc !== {8'd0, v[i]} || c_cnt !== 4'd1 || c_busy !== 1'b0) begin
        fails++; $display("FAIL len1_p%0d vld=%b acc=%0d cnt=%0d busy=%b exp 1/%0d/1/0", i, c_acc_valid, c_acc, c_cnt, c_busy, v[i]); end
      tick();
      asserts++; if (c_acc_valid !== 1'b0 || c_acc !== 24'd0 || c_ready !== 1'b1) begin
        fails++; $display("FAIL len1_clear%0d vld=%b acc=%0d rdy=%b exp 0/0/1", i, c_acc_valid, c_acc, c_ready); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_hold_backpressure();
    test_early_last();
    test_overflow();
    test_mid_reset();
    test_len1();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
